// File: rtl/sevenseg_scan_capture.sv
// sevenseg_scan_capture: recovers BCD digits, decimal points and frame timing
// from a sampled, multiplexed 7-segment display drive. A stability filter
// accepts each held {seg,dig} sample exactly once, so the captured values
// ignore ghosting while the scan moves from one digit to the next.

// One digit position: keeps the last accepted value and a written-once flag.
module sevenseg_digit_slot (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [3:0] bcd_in,
    input  logic       dp_in,
    output logic [3:0] bcd,
    output logic       dp,
    output logic       valid
);
    logic [3:0] bcd_q, bcd_d;
    logic       dp_q, dp_d;
    logic       valid_q, valid_d;

    // Load a new value only when this position is the accepted digit.
    always_comb begin
        bcd_d   = bcd_q;
        dp_d    = dp_q;
        valid_d = valid_q;
        if (wr_en) begin
            bcd_d   = bcd_in;
            dp_d    = dp_in;
            valid_d = 1'b1;
        end
    end

    // Slot registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q   <= 4'h0;
            dp_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            bcd_q   <= bcd_d;
            dp_q    <= dp_d;
            valid_q <= valid_d;
        end
    end

    assign bcd   = bcd_q;
    assign dp    = dp_q;
    assign valid = valid_q;
endmodule

module sevenseg_scan_capture #(
    parameter int N_DIG          = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    parameter int STABLE_CNT     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         seg,
    input  logic [N_DIG-1:0]   dig,
    output logic [4*N_DIG-1:0] digits_bcd,
    output logic [N_DIG-1:0]   dp_mask,
    output logic [N_DIG-1:0]   digit_valid,
    output logic               frame_strobe,
    output logic               frame_valid,
    output logic               err_pattern,
    output logic               err_dig
);
    localparam int               CW      = 8;
    localparam logic [CW-1:0]    CNT_MAX = CW'(STABLE_CNT - 1);
    localparam logic [N_DIG-1:0] DIG_ONE = N_DIG'(1);

    // Segment pattern (g..a, active high) to {hit, value}; blank maps to F.
    function automatic logic [4:0] decode7(input logic [6:0] p);
        case (p)
            7'b0111111: decode7 = {1'b1, 4'd0};
            7'b0000110: decode7 = {1'b1, 4'd1};
            7'b1011011: decode7 = {1'b1, 4'd2};
            7'b1001111: decode7 = {1'b1, 4'd3};
            7'b1100110: decode7 = {1'b1, 4'd4};
            7'b1101101: decode7 = {1'b1, 4'd5};
            7'b1111101: decode7 = {1'b1, 4'd6};
            7'b0000111: decode7 = {1'b1, 4'd7};
            7'b1111111: decode7 = {1'b1, 4'd8};
            7'b1101111: decode7 = {1'b1, 4'd9};
            7'b0000000: decode7 = {1'b1, 4'hF};
            default:    decode7 = 5'b0;
        endcase
    endfunction

    // Held sample is stored already normalised to active-high.
    logic [7:0]       s_q, s_d;
    logic [N_DIG-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             acc_q, acc_d;
    logic [N_DIG-1:0] seen_q, seen_d;
    logic             frame_valid_q, frame_valid_d;
    logic             frame_strobe_q, frame_strobe_d;
    logic             err_pattern_q, err_pattern_d;
    logic             err_dig_q, err_dig_d;

    logic [7:0]       seg_n;
    logic [N_DIG-1:0] dig_n;
    logic             changed;
    logic             accept;
    logic [4:0]       dec;
    logic             dig_none;
    logic             dig_one;
    logic [N_DIG-1:0] wr_en;
    logic [N_DIG-1:0] seen_all;

    // Normalise pins, filter for stability, and classify the accepted sample.
    always_comb begin
        seg_n    = SEG_ACTIVE_LOW ? ~seg : seg;
        dig_n    = DIG_ACTIVE_LOW ? ~dig : dig;
        changed  = (seg_n != s_q) || (dig_n != d_q);
        accept   = (cnt_q == CNT_MAX) && !acc_q;
        dec      = decode7(s_q[6:0]);
        dig_none = (d_q == '0);
        dig_one  = !dig_none && ((d_q & (d_q - DIG_ONE)) == '0);

        s_d = seg_n;
        d_d = dig_n;
        if (changed) begin
            cnt_d = '0;
            acc_d = 1'b0;
        end else begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
            acc_d = acc_q | accept;
        end

        wr_en = '0;
        if (accept && dig_one && dec[4])
            wr_en = d_q;
        seen_all = seen_q | wr_en;

        // The frame closes on the write that completes the seen-mask.
        frame_strobe_d = (wr_en != '0) && (seen_all == '1);
        seen_d         = frame_strobe_d ? '0 : seen_all;
        frame_valid_d  = frame_valid_q | frame_strobe_d;
        err_pattern_d  = accept && dig_one && !dec[4];
        err_dig_d      = accept && !dig_none && !dig_one;
    end

    // Sample, filter and frame-tracking registers; reset loads the idle sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q            <= '0;
            d_q            <= '0;
            cnt_q          <= '0;
            acc_q          <= 1'b0;
            seen_q         <= '0;
            frame_valid_q  <= 1'b0;
            frame_strobe_q <= 1'b0;
            err_pattern_q  <= 1'b0;
            err_dig_q      <= 1'b0;
        end else begin
            s_q            <= s_d;
            d_q            <= d_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            seen_q         <= seen_d;
            frame_valid_q  <= frame_valid_d;
            frame_strobe_q <= frame_strobe_d;
            err_pattern_q  <= err_pattern_d;
            err_dig_q      <= err_dig_d;
        end
    end

    for (genvar i = 0; i < N_DIG; i++) begin : g_slot
        sevenseg_digit_slot u_slot (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (wr_en[i]),
            .bcd_in (dec[3:0]),
            .dp_in  (s_q[7]),
            .bcd    (digits_bcd[4*i +: 4]),
            .dp     (dp_mask[i]),
            .valid  (digit_valid[i])
        );
    end

    assign frame_strobe = frame_strobe_q;
    assign frame_valid  = frame_valid_q;
    assign err_pattern  = err_pattern_q;
    assign err_dig      = err_dig_q;
endmodule

// File: tb/tb_sevenseg_scan_capture.sv
// Bench for sevenseg_scan_capture: directed vector table plus random scans on
// the default instance against a run-length reference model, and a short
// hand sequence on a 6-digit active-high, STABLE_CNT=1 instance.
module tb_sevenseg_scan_capture;
    localparam int S = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic [15:0] digits_bcd;
    logic [3:0]  dp_mask, digit_valid;
    logic        frame_strobe, frame_valid, err_pattern, err_dig;

    logic        rst6;
    logic [7:0]  seg6;
    logic [5:0]  dig6;
    logic [23:0] digits_bcd6;
    logic [5:0]  dp_mask6, digit_valid6;
    logic        frame_strobe6, frame_valid6, err_pattern6, err_dig6;

    sevenseg_scan_capture dut (
        .clk(clk), .rst(rst), .seg(seg), .dig(dig),
        .digits_bcd(digits_bcd), .dp_mask(dp_mask), .digit_valid(digit_valid),
        .frame_strobe(frame_strobe), .frame_valid(frame_valid),
        .err_pattern(err_pattern), .err_dig(err_dig)
    );

    sevenseg_scan_capture #(
        .N_DIG(6), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0), .STABLE_CNT(1)
    ) dut6 (
        .clk(clk), .rst(rst6), .seg(seg6), .dig(dig6),
        .digits_bcd(digits_bcd6), .dp_mask(dp_mask6), .digit_valid(digit_valid6),
        .frame_strobe(frame_strobe6), .frame_valid(frame_valid6),
        .err_pattern(err_pattern6), .err_dig(err_dig6)
    );

    int checks = 0;
    int errors = 0;
    int n_fs, n_ep, n_ed;

    logic [6:0] segs_tbl [10];

    // Reference model state (active-high view of the pins).
    logic [7:0]  m_s;
    logic [3:0]  m_d;
    int          m_run;
    logic        m_done;
    logic [15:0] m_bcd;
    logic [3:0]  m_dp, m_val, m_seen;
    logic        m_fv, m_fs, m_ep, m_ed;

    typedef struct {
        logic        r;
        logic [3:0]  d;
        logic [7:0]  s;
        int          hold;
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic [3:0]  val;
        logic        fv;
        int          fs;
        int          ep;
        int          ed;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lookup(input logic [6:0] p);
        int r;
        r = (p == 7'd0) ? 15 : -1;
        for (int v = 0; v < 10; v++)
            if (segs_tbl[v] == p) r = v;
        return r;
    endfunction

    // A held sample is taken once it has been seen on S consecutive edges.
    task automatic model_edge(input logic r, input logic [7:0] sr, input logic [3:0] dr);
        logic [7:0] sn;
        logic [3:0] dn;
        int ones, idx, v;
        sn = ~sr;
        dn = ~dr;
        m_fs = 1'b0; m_ep = 1'b0; m_ed = 1'b0;
        if (r) begin
            m_s = '0; m_d = '0; m_run = 1; m_done = 1'b0;
            m_bcd = '0; m_dp = '0; m_val = '0; m_seen = '0; m_fv = 1'b0;
        end else begin
            if (m_run >= S && !m_done) begin
                m_done = 1'b1;
                ones = 0;
                idx = 0;
                for (int i = 0; i < 4; i++)
                    if (m_d[i]) begin ones++; idx = i; end
                if (ones > 1) m_ed = 1'b1;
                else if (ones == 1) begin
                    v = lookup(m_s[6:0]);
                    if (v < 0) m_ep = 1'b1;
                    else begin
                        m_bcd[4*idx +: 4] = 4'(v);
                        m_dp[idx]   = m_s[7];
                        m_val[idx]  = 1'b1;
                        m_seen[idx] = 1'b1;
                        if (m_seen == 4'hF) begin
                            m_fs = 1'b1; m_fv = 1'b1; m_seen = '0;
                        end
                    end
                end
            end
            if (sn != m_s || dn != m_d) begin
                m_s = sn; m_d = dn; m_run = 1; m_done = 1'b0;
            end else if (m_run < 1000) begin
                m_run++;
            end
        end
    endtask

    task automatic tick(input logic r, input logic [7:0] s, input logic [3:0] d);
        rst = r; seg = s; dig = d;
        @(posedge clk);
        model_edge(r, s, d);
        #1;
        chk("bcd", 32'(digits_bcd), 32'(m_bcd));
        chk("dp_mask", 32'(dp_mask), 32'(m_dp));
        chk("digit_valid", 32'(digit_valid), 32'(m_val));
        chk("frame_strobe", 32'(frame_strobe), 32'(m_fs));
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("err_pattern", 32'(err_pattern), 32'(m_ep));
        chk("err_dig", 32'(err_dig), 32'(m_ed));
        if (frame_strobe) n_fs++;
        if (err_pattern) n_ep++;
        if (err_dig) n_ed++;
    endtask

    task automatic tick6(input logic r, input logic [7:0] s, input logic [5:0] d);
        rst6 = r; seg6 = s; dig6 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [3:0] d, input logic [7:0] s, input int hold,
                       input logic [15:0] bcd, input logic [3:0] dp, input logic [3:0] val,
                       input logic fv, input int fs, input int ep, input int ed);
        vec_t v;
        v.r = r; v.d = d; v.s = s; v.hold = hold; v.bcd = bcd; v.dp = dp; v.val = val;
        v.fv = fv; v.fs = fs; v.ep = ep; v.ed = ed;
        tbl.push_back(v);
    endtask

    initial begin
        segs_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        rst = 1'b1; seg = 8'hFF; dig = 4'hF;
        rst6 = 1'b1; seg6 = 8'h00; dig6 = 6'h00;
        m_s = '0; m_d = '0; m_run = 1; m_done = 1'b0;
        m_bcd = '0; m_dp = '0; m_val = '0; m_seen = '0;
        m_fv = 1'b0; m_fs = 1'b0; m_ep = 1'b0; m_ed = 1'b0;

        //   r  dig    seg    hold bcd       dp     val    fv fs ep ed
        add(1, 4'hF, 8'hFF, 1, 16'h0000, 4'h0, 4'h0, 0, 0, 0, 0); // reset
        add(0, 4'hE, 8'hF9, 4, 16'h0000, 4'h0, 4'h0, 0, 0, 0, 0); // "1" not yet
        add(0, 4'hE, 8'hF9, 2, 16'h0001, 4'h0, 4'h1, 0, 0, 0, 0); // accepted
        add(0, 4'hE, 8'hA4, 3, 16'h0001, 4'h0, 4'h1, 0, 0, 0, 0); // short glitch
        add(1, 4'hF, 8'hFF, 1, 16'h0000, 4'h0, 4'h0, 0, 0, 0, 0);
        add(0, 4'h7, 8'hA4, 6, 16'h2000, 4'h0, 4'h8, 0, 0, 0, 0); // "2"
        add(0, 4'hF, 8'hFF, 2, 16'h2000, 4'h0, 4'h8, 0, 0, 0, 0);
        add(0, 4'hB, 8'h92, 6, 16'h2500, 4'h0, 4'hC, 0, 0, 0, 0); // "5"
        add(0, 4'hF, 8'hFF, 2, 16'h2500, 4'h0, 4'hC, 0, 0, 0, 0);
        add(0, 4'hD, 8'h30, 6, 16'h2530, 4'h2, 4'hE, 0, 0, 0, 0); // "3."
        add(0, 4'hF, 8'hFF, 2, 16'h2530, 4'h2, 4'hE, 0, 0, 0, 0);
        add(0, 4'hE, 8'hF8, 6, 16'h2537, 4'h2, 4'hF, 1, 1, 0, 0); // "7" closes frame
        add(0, 4'hF, 8'hFF, 2, 16'h2537, 4'h2, 4'hF, 1, 0, 0, 0);
        add(0, 4'hD, 8'h00, 6, 16'h2587, 4'h2, 4'hF, 1, 0, 0, 0); // "8."
        add(0, 4'hF, 8'hFF, 2, 16'h2587, 4'h2, 4'hF, 1, 0, 0, 0);
        add(0, 4'hD, 8'hD5, 6, 16'h2587, 4'h2, 4'hF, 1, 0, 1, 0); // bad pattern
        add(0, 4'hF, 8'hFF, 2, 16'h2587, 4'h2, 4'hF, 1, 0, 0, 0);
        add(0, 4'hC, 8'hF9, 6, 16'h2587, 4'h2, 4'hF, 1, 0, 0, 1); // two digits
        add(0, 4'hF, 8'hFF, 2, 16'h2587, 4'h2, 4'hF, 1, 0, 0, 0);
        add(1, 4'hF, 8'hFF, 1, 16'h0000, 4'h0, 4'h0, 0, 0, 0, 0);
        add(0, 4'hE, 8'h99, 6, 16'h0004, 4'h0, 4'h1, 0, 0, 0, 0); // partial frame
        add(0, 4'hF, 8'hFF, 2, 16'h0004, 4'h0, 4'h1, 0, 0, 0, 0);
        add(0, 4'hD, 8'h82, 6, 16'h0064, 4'h0, 4'h3, 0, 0, 0, 0);
        add(1, 4'hF, 8'hFF, 1, 16'h0000, 4'h0, 4'h0, 0, 0, 0, 0); // reset mid-frame
        add(0, 4'hE, 8'hF9, 6, 16'h0001, 4'h0, 4'h1, 0, 0, 0, 0);
        add(0, 4'hD, 8'hA4, 6, 16'h0021, 4'h0, 4'h3, 0, 0, 0, 0);
        add(0, 4'hB, 8'hB0, 6, 16'h0321, 4'h0, 4'h7, 0, 0, 0, 0);
        add(0, 4'h7, 8'h99, 6, 16'h4321, 4'h0, 4'hF, 1, 1, 0, 0);

        foreach (tbl[k]) begin
            n_fs = 0; n_ep = 0; n_ed = 0;
            for (int c = 0; c < tbl[k].hold; c++)
                tick(tbl[k].r, tbl[k].s, tbl[k].d);
            chk($sformatf("v%0d_bcd", k), 32'(digits_bcd), 32'(tbl[k].bcd));
            chk($sformatf("v%0d_dp", k), 32'(dp_mask), 32'(tbl[k].dp));
            chk($sformatf("v%0d_valid", k), 32'(digit_valid), 32'(tbl[k].val));
            chk($sformatf("v%0d_fvalid", k), 32'(frame_valid), 32'(tbl[k].fv));
            chk($sformatf("v%0d_n_strobe", k), 32'(n_fs), 32'(tbl[k].fs));
            chk($sformatf("v%0d_n_errpat", k), 32'(n_ep), 32'(tbl[k].ep));
            chk($sformatf("v%0d_n_errdig", k), 32'(n_ed), 32'(tbl[k].ed));
        end

        // Random scans: mostly legal digits, some junk patterns and selects.
        for (int g = 0; g < 120; g++) begin
            int kind, hold, idx, v;
            logic r;
            logic dpb;
            logic [6:0] pat;
            logic [7:0] s;
            logic [3:0] d;
            kind = $urandom_range(0, 99);
            hold = $urandom_range(1, 7);
            idx  = $urandom_range(0, 3);
            r    = 1'b0;
            if (kind < 70) begin
                v   = $urandom_range(0, 10);
                dpb = 1'($urandom_range(0, 1));
                pat = (v == 10) ? 7'd0 : segs_tbl[v];
                s   = ~{dpb, pat};
                d   = ~(4'b0001 << idx);
            end else if (kind < 82) begin
                s = 8'($urandom);
                d = ~(4'b0001 << idx);
            end else if (kind < 96) begin
                s = 8'($urandom);
                d = 4'($urandom);
            end else begin
                r = 1'b1; hold = 1; s = 8'hFF; d = 4'hF;
            end
            for (int c = 0; c < hold; c++)
                tick(r, s, d);
        end

        // Six digits, active-high pins, one-cycle acceptance.
        tick6(1'b1, 8'h00, 6'h00);
        chk("p6_rst_bcd", 32'(digits_bcd6), 32'h0);
        chk("p6_rst_valid", 32'(digit_valid6), 32'h0);
        chk("p6_rst_fvalid", 32'(frame_valid6), 32'h0);
        for (int j = 0; j < 6; j++) begin
            tick6(1'b0, {1'b0, 7'h6F}, 6'(1 << j));
            chk($sformatf("p6_valid_%0d", j), 32'(digit_valid6), 32'(6'((1 << j) - 1)));
            chk($sformatf("p6_strobe_%0d", j), 32'(frame_strobe6), 32'h0);
        end
        tick6(1'b0, 8'h00, 6'h00);
        chk("p6_bcd", 32'(digits_bcd6), 32'h999999);
        chk("p6_strobe", 32'(frame_strobe6), 32'h1);
        chk("p6_valid", 32'(digit_valid6), 32'h3F);
        chk("p6_dp", 32'(dp_mask6), 32'h0);
        chk("p6_errs", 32'({err_pattern6, err_dig6}), 32'h0);
        tick6(1'b0, 8'h00, 6'h00);
        chk("p6_strobe_off", 32'(frame_strobe6), 32'h0);
        chk("p6_fvalid", 32'(frame_valid6), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
